// File: rtl/cluster_tx_scheduler.sv
// Cluster TX scheduler: captures the 8 sorted clusters each BX, queues non-empty frames, serializes one cluster per clock.
// Latency: 2 edges from bx_strobe to tx_valid when the FIFO is empty and the serializer is idle.
// Backpressure: tx_ready low holds tx_data/tx_last; a full frame FIFO drops new frames and counts them in overflow_cnt.
// Build option: CLUSTER_SCHED_EMPTY_FRAME_EN queues empty crossings and emits one {3'd0,11'h7FF} word for each.
module cluster_tx_scheduler #(
   parameter int MXCLSTBITS   = 14,
   parameter int MXADRBITS    = 11,
   parameter int MXCLUSTERS   = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_ADRBITS = 3
) (
   input  logic                             clock4x,
   input  logic                             global_reset_n,
   input  logic                             bx_strobe,
   input  logic [MXCLUSTERS*MXCLSTBITS-1:0] cluster_in,
   input  logic                             ttc_resync,
   input  logic                             tx_ready,
   output logic                             tx_valid,
   output logic [MXCLSTBITS-1:0]            tx_data,
   output logic                             tx_last,
   output logic [FIFO_ADRBITS:0]            fifo_count,
   output logic                             overflow,
   output logic [15:0]                      overflow_cnt
);

   localparam int NVW     = $clog2(MXCLUSTERS + 1);
   localparam int IDXW    = $clog2(MXCLUSTERS);
   localparam int CLW     = MXCLUSTERS * MXCLSTBITS;
   localparam int FRAME_W = CLW + NVW;
   localparam logic [MXADRBITS-1:0]  ADR_LIMIT  = MXADRBITS'(1536);
   localparam logic [MXCLSTBITS-1:0] EMPTY_WORD = MXCLSTBITS'(11'h7FF);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state_q;
   logic [FRAME_W-1:0]      mem_q [FIFO_DEPTH];
   logic [FIFO_ADRBITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_ADRBITS:0]   cnt_q, cnt_d;
   logic [CLW-1:0]          cur_q;
   logic [NVW-1:0]          cur_n_q;
   logic [IDXW-1:0]         idx_q, idx_nxt;
   logic                    tx_valid_q, tx_last_q;
   logic [MXCLSTBITS-1:0]   tx_data_q;
   logic                    overflow_q;
   logic [15:0]             overflow_cnt_q;

   logic [NVW-1:0]          nvalid;
   logic                    run;
   logic                    frame_ok, wr_req, full, empty, wr_en, drop;
   logic                    last_xfer, adv, pop;
   logic [FRAME_W-1:0]      head;
   logic [NVW-1:0]          head_n;

   // Leading-valid count: stop at the first cluster with an out-of-range address.
   always_comb begin
      nvalid = '0;
      run    = 1'b1;
      for (int k = 0; k < MXCLUSTERS; k++) begin
         if (run && (cluster_in[k*MXCLSTBITS +: MXADRBITS] < ADR_LIMIT))
            nvalid = nvalid + NVW'(1);
         else
            run = 1'b0;
      end
   end

`ifdef CLUSTER_SCHED_EMPTY_FRAME_EN
   assign frame_ok = 1'b1;
`else
   assign frame_ok = (nvalid != '0);
`endif

   // Fullness is taken from the registered count, so a same-edge pop never rescues a frame.
   assign wr_req    = bx_strobe && !ttc_resync && frame_ok;
   assign full      = (cnt_q == (FIFO_ADRBITS+1)'(FIFO_DEPTH));
   assign empty     = (cnt_q == '0);
   assign wr_en     = wr_req && !full;
   assign drop      = wr_req && full;
   assign head      = mem_q[rd_ptr_q];
   assign head_n    = head[FRAME_W-1 -: NVW];
   assign last_xfer = (state_q == SEND) && tx_ready && tx_last_q;
   assign adv       = (state_q == SEND) && tx_ready && !tx_last_q;
   assign pop       = !ttc_resync && !empty && ((state_q == IDLE) || last_xfer);
   assign idx_nxt   = idx_q + IDXW'(1);

   // Occupancy: simultaneous write and pop leave the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (wr_en && !pop)
         cnt_d = cnt_q + (FIFO_ADRBITS+1)'(1);
      else if (!wr_en && pop)
         cnt_d = cnt_q - (FIFO_ADRBITS+1)'(1);
   end

   // Frame storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clock4x) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= {nvalid, cluster_in};
   end

   // FIFO pointers and count; resync flushes everything queued.
   always_ff @(posedge clock4x or negedge global_reset_n) begin
      if (!global_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (ttc_resync) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_ADRBITS'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_ADRBITS'(1);
         cnt_q <= cnt_d;
      end
   end

   // Serializer FSM with registered word outputs; a last-word handshake chains straight into the next frame.
   always_ff @(posedge clock4x or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q    <= IDLE;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         tx_last_q  <= 1'b0;
         cur_q      <= '0;
         cur_n_q    <= '0;
         idx_q      <= '0;
      end else if (ttc_resync) begin
         state_q    <= IDLE;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
      end else if (pop) begin
         state_q    <= SEND;
         tx_valid_q <= 1'b1;
         cur_q      <= head[CLW-1:0];
         cur_n_q    <= head_n;
         idx_q      <= '0;
         // An empty frame only exists with the empty-frame build option; it carries a fixed marker word.
         tx_data_q  <= (head_n == '0) ? EMPTY_WORD : head[MXCLSTBITS-1:0];
         tx_last_q  <= (head_n <= NVW'(1));
      end else if (adv) begin
         idx_q      <= idx_nxt;
         tx_data_q  <= cur_q[idx_nxt*MXCLSTBITS +: MXCLSTBITS];
         tx_last_q  <= ((NVW'(idx_nxt) + NVW'(1)) == cur_n_q);
      end else if (last_xfer) begin
         state_q    <= IDLE;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
      end
   end

   // Drop accounting: one-cycle pulse per dropped frame and a saturating counter.
   always_ff @(posedge clock4x or negedge global_reset_n) begin
      if (!global_reset_n) begin
         overflow_q     <= 1'b0;
         overflow_cnt_q <= '0;
      end else if (ttc_resync) begin
         overflow_q     <= 1'b0;
         overflow_cnt_q <= '0;
      end else begin
         overflow_q <= drop;
         if (drop && (overflow_cnt_q != 16'hFFFF))
            overflow_cnt_q <= overflow_cnt_q + 16'd1;
      end
   end

   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;
   assign tx_last      = tx_last_q;
   assign fifo_count   = cnt_q;
   assign overflow     = overflow_q;
   assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Bench for cluster_tx_scheduler: scoreboard of expected {last,word} pushed at bx_strobe, popped on each handshake.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Stall cycles are checked for tx_data/tx_last stability.
module tb_cluster_tx_scheduler;

   localparam int CW  = 14;
   localparam int NCL = 8;

   logic              clock4x = 1'b0;
   logic              global_reset_n = 1'b0;
   logic              bx_strobe = 1'b0;
   logic [NCL*CW-1:0] cluster_in = '0;
   logic              ttc_resync = 1'b0;
   logic              tx_ready = 1'b0;
   logic              tx_valid;
   logic [CW-1:0]     tx_data;
   logic              tx_last;
   logic [3:0]        fifo_count;
   logic              overflow;
   logic [15:0]       overflow_cnt;

   cluster_tx_scheduler dut (
      .clock4x        (clock4x),
      .global_reset_n (global_reset_n),
      .bx_strobe      (bx_strobe),
      .cluster_in     (cluster_in),
      .ttc_resync     (ttc_resync),
      .tx_ready       (tx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_last        (tx_last),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .overflow_cnt   (overflow_cnt)
   );

   always #5 clock4x = ~clock4x;

   int          errors = 0;
   int          checks = 0;
   logic [14:0] exp_q [$];
   logic [14:0] mon_e;
   bit          mon_en = 1'b0;
   bit          stall_prev = 1'b0;
   logic [CW-1:0] stall_dat;
   logic        stall_last;
   int          run_len = 0;
   int          last_run = 0;
   int          ovf_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] mk(input int cnt, input int adr);
      mk = {cnt[2:0], adr[10:0]};
   endfunction

   // n leading valid clusters at addresses base+k, the rest marked invalid with 0x7FF
   function automatic logic [NCL*CW-1:0] frame_of(input int base, input int n);
      logic [NCL*CW-1:0] f;
      f = '0;
      for (int k = 0; k < NCL; k++)
         f[k*CW +: CW] = (k < n) ? mk(k, base + k) : mk(0, 'h7FF);
      return f;
   endfunction

   // Push expectations for a frame, then drive a one-cycle strobe and idle 3 cycles.
   task automatic send_bx(input logic [NCL*CW-1:0] cl, input bit drop);
      int n;
      n = 0;
      for (int k = 0; k < NCL; k++) begin
         if (cl[k*CW +: 11] >= 11'd1536) break;
         n++;
      end
      if (!drop) begin
         if (n == 0) begin
`ifdef CLUSTER_SCHED_EMPTY_FRAME_EN
            exp_q.push_back({1'b1, 14'h07FF});
`endif
         end else begin
            for (int k = 0; k < n; k++)
               exp_q.push_back({(k == n - 1), cl[k*CW +: CW]});
         end
      end
      @(posedge clock4x); #1;
      bx_strobe  = 1'b1;
      cluster_in = cl;
      @(posedge clock4x); #1;
      bx_strobe  = 1'b0;
      repeat (2) @(posedge clock4x);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || tx_valid) && i < budget) begin
         @(posedge clock4x); #1;
         i++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   // Output monitor: scoreboard compare on handshakes, hold check on stalls.
   always @(negedge clock4x) begin
      if (overflow) ovf_pulses++;
      if (tx_valid) run_len++;
      else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
      if (!mon_en) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_vld", tx_valid, 1);
            chk("hold_dat", tx_data, stall_dat);
            chk("hold_last", tx_last, stall_last);
         end
         stall_prev = 1'b0;
         if (tx_valid && !tx_ready) begin
            stall_prev = 1'b1;
            stall_dat  = tx_data;
            stall_last = tx_last;
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word_dat", tx_data, mon_e[13:0]);
               chk("word_last", tx_last, mon_e[14]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NCL*CW-1:0] cl;

      // Reset state
      repeat (3) @(posedge clock4x);
      #1;
      chk("rst_vld", tx_valid, 0);
      chk("rst_dat", tx_data, 0);
      chk("rst_last", tx_last, 0);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ovf_cnt", overflow_cnt, 0);
      global_reset_n = 1'b1;
      tx_ready = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clock4x);
      #1;

      // Three-cluster frame: 2-edge latency, words 5/100/1535, last on 1535
      cl = frame_of(0, 0);
      cl[0*CW +: CW] = mk(1, 5);
      cl[1*CW +: CW] = mk(2, 100);
      cl[2*CW +: CW] = mk(3, 1535);
      exp_q.push_back({1'b0, mk(1, 5)});
      exp_q.push_back({1'b0, mk(2, 100)});
      exp_q.push_back({1'b1, mk(3, 1535)});
      @(posedge clock4x); #1;
      bx_strobe = 1'b1;
      cluster_in = cl;
      @(posedge clock4x); #1;
      bx_strobe = 1'b0;
      chk("lat_n_vld", tx_valid, 0);
      chk("lat_n_cnt", fifo_count, 1);
      @(posedge clock4x); #1;
      chk("lat_n1_vld", tx_valid, 1);
      chk("lat_n1_cnt", fifo_count, 0);
      wait_idle(20);

      // Empty crossing: cluster0 invalid, cluster1 valid but ignored
      cl = frame_of(0, 0);
      cl[1*CW +: CW] = mk(1, 10);
      send_bx(cl, 1'b0);
`ifndef CLUSTER_SCHED_EMPTY_FRAME_EN
      chk("empty_cnt", fifo_count, 0);
      chk("empty_vld", tx_valid, 0);
`endif
      wait_idle(20);

      // Stall for 5 cycles mid-frame
      send_bx(frame_of(200, 6), 1'b0);
      tx_ready = 1'b0;
      repeat (5) @(posedge clock4x);
      #1;
      tx_ready = 1'b1;
      wait_idle(30);

      // Two full frames back-to-back with no bubble
      send_bx(frame_of(300, 8), 1'b0);
      send_bx(frame_of(400, 8), 1'b0);
      wait_idle(40);
      @(negedge clock4x); #1;
      chk("no_bubble_run", last_run, 16);

      // Overflow: one frame sits in the serializer, 8 fill the FIFO, the 10th is dropped
      tx_ready = 1'b0;
      ovf_pulses = 0;
      for (int f = 0; f < 10; f++) begin
         if (f == 9) chk("ovf_cnt_pre", overflow_cnt, 0);
         send_bx(frame_of(f * 8, 8), (f == 9));
      end
      chk("ovf_fifo_cnt", fifo_count, 8);
      chk("ovf_cnt", overflow_cnt, 1);
      chk("ovf_pulses", ovf_pulses, 1);
      tx_ready = 1'b1;
      wait_idle(150);
      chk("ovf_cnt_kept", overflow_cnt, 1);

      // Resync with 3 frames queued and a strobe on the resync edge
      tx_ready = 1'b0;
      for (int f = 0; f < 4; f++) send_bx(frame_of(500 + f * 8, 8), 1'b0);
      chk("rs_pre_cnt", fifo_count, 3);
      mon_en = 1'b0;
      ttc_resync = 1'b1;
      bx_strobe = 1'b1;
      cluster_in = frame_of(600, 8);
      @(posedge clock4x); #1;
      ttc_resync = 1'b0;
      bx_strobe = 1'b0;
      exp_q.delete();
      chk("rs_vld", tx_valid, 0);
      chk("rs_cnt", fifo_count, 0);
      chk("rs_ovf_cnt", overflow_cnt, 0);
      repeat (3) @(posedge clock4x);
      #1;
      chk("rs_cnt_after", fifo_count, 0);
      chk("rs_vld_after", tx_valid, 0);
      tx_ready = 1'b1;
      mon_en = 1'b1;

      // Asynchronous reset mid-frame
      send_bx(frame_of(700, 8), 1'b0);
      mon_en = 1'b0;
      global_reset_n = 1'b0;
      #2;
      chk("arst_vld", tx_valid, 0);
      chk("arst_dat", tx_data, 0);
      chk("arst_last", tx_last, 0);
      exp_q.delete();
      @(posedge clock4x); #1;
      global_reset_n = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(posedge clock4x);
      #1;
      chk("arst_vld_after", tx_valid, 0);
      chk("arst_cnt_after", fifo_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
